// File: rtl/gamepad_pkg.sv
// Shared constants and types for the gamepad input engine.
package gamepad_pkg;

  localparam int unsigned BTN_W = 12;

  // Bit positions within one pad word, MSB first as shifted by the controller
  localparam int unsigned BTN_B      = 11;
  localparam int unsigned BTN_Y      = 10;
  localparam int unsigned BTN_SELECT = 9;
  localparam int unsigned BTN_START  = 8;
  localparam int unsigned BTN_UP     = 7;
  localparam int unsigned BTN_DOWN   = 6;
  localparam int unsigned BTN_LEFT   = 5;
  localparam int unsigned BTN_RIGHT  = 4;
  localparam int unsigned BTN_A      = 3;
  localparam int unsigned BTN_X      = 2;
  localparam int unsigned BTN_L      = 1;
  localparam int unsigned BTN_R      = 0;

  // A pad that was never clocked reads all ones
  localparam logic [BTN_W-1:0] PAD_ABSENT = 12'hFFF;
  localparam logic [BTN_W-1:0] DPAD_MASK  = 12'h0F0;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

endpackage

// File: rtl/gamepad_input_engine_pad_events.sv
// Per-pad presence decode, press/release edge detection and auto-repeat.
// Auto-repeat is only built when GAMEPAD_AUTOREPEAT_EN is defined.
module gamepad_pad_events
  import gamepad_pkg::*;
#(
  parameter logic [BTN_W-1:0] REPEAT_MASK  = DPAD_MASK,
  parameter int unsigned      REPEAT_DELAY = 20,
  parameter int unsigned      REPEAT_RATE  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [BTN_W-1:0] raw,
  input  logic             frame_tick,
  output logic [BTN_W-1:0] held,
  output logic [BTN_W-1:0] pressed,
  output logic [BTN_W-1:0] released,
  output logic [BTN_W-1:0] repeat_pulse,
  output logic             is_present
);

  logic [BTN_W-1:0] held_q, held_d;
  logic [BTN_W-1:0] pressed_q, pressed_d;
  logic [BTN_W-1:0] released_q, released_d;
  logic             present_q, present_d;
  logic [BTN_W-1:0] new_held;

  // Decode presence and compute edge events against the previous level
  always_comb begin
    new_held   = (raw == PAD_ABSENT) ? '0 : raw;
    held_d     = held_q;
    present_d  = present_q;
    pressed_d  = '0;
    released_d = '0;
    if (frame_valid) begin
      held_d     = new_held;
      present_d  = (raw != PAD_ABSENT);
      pressed_d  = new_held & ~held_q;
      released_d = ~new_held & held_q;
    end
  end

  // Level and event registers
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      present_q  <= 1'b0;
    end else begin
      held_q     <= held_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      present_q  <= present_d;
    end
  end

  assign held       = held_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign is_present = present_q;

`ifdef GAMEPAD_AUTOREPEAT_EN
  localparam logic [7:0] DELAY_TICKS = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_TICKS  = 8'(REPEAT_RATE);

  rpt_state_e       state_q, state_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic [7:0]       tick_next;
  logic [BTN_W-1:0] rpt_q, rpt_d;
  logic             mask_change;

  // Repeat pacing; a masked level change in the same cycle as a tick
  // takes priority and swallows that tick
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    rpt_d       = '0;
    tick_next   = tick_cnt_q + 8'd1;
    mask_change = ((held_d ^ held_q) & REPEAT_MASK) != '0;
    if (mask_change) begin
      tick_cnt_d = '0;
      state_d    = ((held_d & REPEAT_MASK) != '0) ? RPT_DELAY : RPT_IDLE;
    end else if (frame_tick && state_q != RPT_IDLE) begin
      if (tick_next == ((state_q == RPT_DELAY) ? DELAY_TICKS : RATE_TICKS)) begin
        rpt_d      = held_q & REPEAT_MASK;
        tick_cnt_d = '0;
        state_d    = RPT_REPEAT;
      end else begin
        tick_cnt_d = tick_next;
      end
    end
  end

  // Auto-repeat state, counter and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RPT_IDLE;
      tick_cnt_q <= '0;
      rpt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      rpt_q      <= rpt_d;
    end
  end

  assign repeat_pulse = rpt_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{frame_tick, REPEAT_MASK, 8'(REPEAT_DELAY), 8'(REPEAT_RATE)};
  assign repeat_pulse = '0;
`endif

endmodule

// File: rtl/gamepad_input_engine.sv
// Gamepad Pmod receiver for 1..4 controllers: synchronisers, frame shift
// register and bit counter, with one gamepad_pad_events per pad.
// Optional auto-repeat: define GAMEPAD_AUTOREPEAT_EN.
module gamepad_input_engine
  import gamepad_pkg::*;
#(
  parameter int unsigned      NUM_PADS     = 2,
  parameter logic [BTN_W-1:0] REPEAT_MASK  = 12'h0F0,
  parameter int unsigned      REPEAT_DELAY = 20,
  parameter int unsigned      REPEAT_RATE  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pmod_data,
  input  logic                      pmod_clk,
  input  logic                      pmod_latch,
  input  logic                      frame_tick,
  output logic [BTN_W*NUM_PADS-1:0] held,
  output logic [BTN_W*NUM_PADS-1:0] pressed,
  output logic [BTN_W*NUM_PADS-1:0] released,
  output logic [BTN_W*NUM_PADS-1:0] repeat_pulse,
  output logic [NUM_PADS-1:0]       is_present,
  output logic                      update,
  output logic                      overrun
);

  localparam int unsigned      BITS    = BTN_W * NUM_PADS;
  localparam int unsigned      CNT_W   = $clog2(BITS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITS + 1);

  if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
    $error("NUM_PADS must be 1..4");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_rpt
    $error("REPEAT_DELAY and REPEAT_RATE must be 1..255");
  end

  // {latch, clk, data}
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  // {latch, clk} delayed once more for edge detection
  logic [1:0]       prev_q, prev_d;
  logic [BITS-1:0]  shift_q, shift_d;
  logic [BITS-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             commit_q, commit_d;
  logic             over_pend_q, over_pend_d;
  logic             update_q, update_d;
  logic             overrun_q, overrun_d;
  logic             clk_rise, latch_rise;

  // Frame assembly; a commit snapshots the shift register before any bit
  // arriving in the same cycle, which then starts the next frame
  always_comb begin
    sync1_d     = {pmod_latch, pmod_clk, pmod_data};
    sync2_d     = sync1_q;
    prev_d      = sync2_q[2:1];
    clk_rise    = sync2_q[1] & ~prev_q[0];
    latch_rise  = sync2_q[2] & ~prev_q[1];
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    commit_d    = 1'b0;
    over_pend_d = 1'b0;
    update_d    = commit_q;
    overrun_d   = over_pend_q;
    if (latch_rise && bit_cnt_q != '0) begin
      frame_d     = shift_q;
      commit_d    = 1'b1;
      over_pend_d = (bit_cnt_q > CNT_W'(BITS));
      shift_d     = '1;
      bit_cnt_d   = '0;
    end
    if (clk_rise) begin
      shift_d = {shift_d[BITS-2:0], sync2_q[0]};
      if (bit_cnt_d != CNT_MAX) begin
        bit_cnt_d = bit_cnt_d + CNT_W'(1);
      end
    end
  end

  // Synchroniser, shift register and commit pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      shift_q     <= '1;
      frame_q     <= '1;
      bit_cnt_q   <= '0;
      commit_q    <= 1'b0;
      over_pend_q <= 1'b0;
      update_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      commit_q    <= commit_d;
      over_pend_q <= over_pend_d;
      update_q    <= update_d;
      overrun_q   <= overrun_d;
    end
  end

  assign update  = update_q;
  assign overrun = overrun_q;

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    gamepad_pad_events #(
      .REPEAT_MASK  (REPEAT_MASK),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_pad (
      .clk          (clk),
      .reset        (reset),
      .frame_valid  (commit_q),
      .raw          (frame_q[BTN_W*k +: BTN_W]),
      .frame_tick   (frame_tick),
      .held         (held[BTN_W*k +: BTN_W]),
      .pressed      (pressed[BTN_W*k +: BTN_W]),
      .released     (released[BTN_W*k +: BTN_W]),
      .repeat_pulse (repeat_pulse[BTN_W*k +: BTN_W]),
      .is_present   (is_present[k])
    );
  end

endmodule

// File: tb/tb_gamepad_input_engine.sv
// Scoreboard bench for gamepad_input_engine (NUM_PADS=2, delay 3, rate 2).
module tb_gamepad_input_engine;

  localparam int unsigned W = 24;
`ifdef GAMEPAD_AUTOREPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pmod_data = 1'b0;
  logic pmod_clk = 1'b0;
  logic pmod_latch = 1'b0;
  logic frame_tick = 1'b0;
  logic [W-1:0] held, pressed, released, repeat_pulse;
  logic [1:0]   is_present;
  logic         update, overrun;

  gamepad_input_engine #(
    .NUM_PADS     (2),
    .REPEAT_MASK  (12'h0F0),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pmod_data    (pmod_data),
    .pmod_clk     (pmod_clk),
    .pmod_latch   (pmod_latch),
    .frame_tick   (frame_tick),
    .held         (held),
    .pressed      (pressed),
    .released     (released),
    .repeat_pulse (repeat_pulse),
    .is_present   (is_present),
    .update       (update),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] held;
    logic [W-1:0] pressed;
    logic [W-1:0] released;
    logic [1:0]   present;
    logic         ovr;
  } frame_exp_t;

  frame_exp_t   frame_sb[$];
  logic [W-1:0] rpt_sb[$];
  frame_exp_t   mon_e;
  logic [W-1:0] mon_r;
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an update or repeat pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (update) begin
        if (frame_sb.size() == 0) begin
          check("unexpected_update", 24'd1, 24'd0);
        end else begin
          mon_e = frame_sb.pop_front();
          check("held", held, mon_e.held);
          check("pressed", pressed, mon_e.pressed);
          check("released", released, mon_e.released);
          check("is_present", {22'd0, is_present}, {22'd0, mon_e.present});
          check("overrun", {23'd0, overrun}, {23'd0, mon_e.ovr});
        end
      end else if (pressed != '0 || released != '0 || overrun) begin
        check("stray_pulse", {pressed | released}, 24'd0);
      end
      if (repeat_pulse != '0) begin
        if (rpt_sb.size() == 0) begin
          check("unexpected_repeat", repeat_pulse, 24'd0);
        end else begin
          mon_r = rpt_sb.pop_front();
          check("repeat_pulse", repeat_pulse, mon_r);
        end
      end
    end
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits, MSB first: pad1 bits go out before pad0 bits
  task automatic send_bits(input logic [31:0] v, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      pmod_data = v[i];
      wait_clk(2);
      pmod_clk = 1'b1;
      wait_clk(2);
      pmod_clk = 1'b0;
      wait_clk(2);
    end
  endtask

  // Latch pulse; optionally raise frame_tick so it is sampled on the commit edge
  task automatic do_latch(input bit tick_at_commit);
    pmod_latch = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (tick_at_commit) frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_clk(2);
    pmod_latch = 1'b0;
    wait_clk(6);
  endtask

  task automatic expect_frame(input logic [W-1:0] h, input logic [W-1:0] p,
                              input logic [W-1:0] r, input logic [1:0] pr, input logic ov);
    frame_exp_t e;
    e.held = h; e.pressed = p; e.released = r; e.present = pr; e.ovr = ov;
    frame_sb.push_back(e);
  endtask

  task automatic tick(input bit pulse_expected, input logic [W-1:0] val);
    if (pulse_expected && RPT_EN) rpt_sb.push_back(val);
    frame_tick = 1'b1;
    wait_clk(1);
    frame_tick = 1'b0;
    wait_clk(9);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("rst_held", held, 24'd0);
    check("rst_pressed", pressed, 24'd0);
    check("rst_released", released, 24'd0);
    check("rst_repeat", repeat_pulse, 24'd0);
    check("rst_present", {22'd0, is_present}, 24'd0);
    check("rst_update", {23'd0, update}, 24'd0);
    check("rst_overrun", {23'd0, overrun}, 24'd0);

    // F1: up on pad0, pad1 present with nothing held
    expect_frame({12'h000, 12'h080}, {12'h000, 12'h080}, 24'd0, 2'b11, 1'b0);
    send_bits({8'd0, 12'h000, 12'h080}, 24);
    do_latch(1'b0);
    tick(1'b0, '0);
    tick(1'b0, '0);
    tick(1'b1, {12'h000, 12'h080});

    // F2: same levels again, repeat keeps running at the rate
    expect_frame({12'h000, 12'h080}, 24'd0, 24'd0, 2'b11, 1'b0);
    send_bits({8'd0, 12'h000, 12'h080}, 24);
    do_latch(1'b0);
    tick(1'b0, '0);
    tick(1'b1, {12'h000, 12'h080});
    tick(1'b0, '0);
    tick(1'b1, {12'h000, 12'h080});

    // F3: release up, repeat stops
    expect_frame(24'd0, 24'd0, {12'h000, 12'h080}, 2'b11, 1'b0);
    send_bits({8'd0, 12'h000, 12'h000}, 24);
    do_latch(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, '0);

    // F4: only 12 bits, pad1 absent; B is not repeat-eligible
    expect_frame({12'h000, 12'h800}, {12'h000, 12'h800}, 24'd0, 2'b01, 1'b0);
    send_bits({20'd0, 12'h800}, 12);
    do_latch(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0);

    // F5: up pressed, B released, enters delay
    expect_frame({12'h000, 12'h080}, {12'h000, 12'h080}, {12'h000, 12'h800}, 2'b11, 1'b0);
    send_bits({8'd0, 12'h000, 12'h080}, 24);
    do_latch(1'b0);
    tick(1'b0, '0);
    tick(1'b0, '0);

    // F6: add left on the same cycle as a tick; change wins, delay restarts
    expect_frame({12'h000, 12'h0A0}, {12'h000, 12'h020}, 24'd0, 2'b11, 1'b0);
    send_bits({8'd0, 12'h000, 12'h0A0}, 24);
    do_latch(1'b1);
    tick(1'b0, '0);
    tick(1'b0, '0);
    tick(1'b1, {12'h000, 12'h0A0});

    // F7: 26 bits, last 24 committed and overrun flagged
    expect_frame({12'h003, 12'h0A0}, {12'h003, 12'h000}, 24'd0, 2'b11, 1'b1);
    send_bits({6'd0, 2'b01, 12'h003, 12'h0A0}, 26);
    do_latch(1'b0);

    // Latch with no bits clocked: ignored
    do_latch(1'b0);

    // Reset mid-frame discards the partial bits
    send_bits({25'd0, 7'h55}, 7);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    check("midrst_held", held, 24'd0);
    check("midrst_present", {22'd0, is_present}, 24'd0);

    // F8: clean frame after reset, no overrun from leftover bits
    expect_frame({12'h000, 12'h040}, {12'h000, 12'h040}, 24'd0, 2'b11, 1'b0);
    send_bits({8'd0, 12'h000, 12'h040}, 24);
    do_latch(1'b0);

    wait_clk(20);
    check("pending_frames", 24'(frame_sb.size()), 24'd0);
    check("pending_repeats", 24'(rpt_sb.size()), 24'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
